// File: rtl/rvc_asap_cr_mem.sv
// Control-register responder for the rvc_asap core: display registers, debounced buttons,
// synchronized switches, with registered (one-cycle) read data.
module rvc_asap_cr_mem #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        Clock,
    input  logic        RstN,
    input  logic [31:0] CrAddr,
    input  logic        CrRdEn,
    input  logic        CrWrEn,
    input  logic [3:0]  CrByteEn,
    input  logic [31:0] CrWrData,
    output logic [31:0] CrRdData,
    input  logic        Button_0,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    output logic [6:0]  SEG7_0,
    output logic [6:0]  SEG7_1,
    output logic [6:0]  SEG7_2,
    output logic [6:0]  SEG7_3,
    output logic [6:0]  SEG7_4,
    output logic [6:0]  SEG7_5,
    output logic [6:0]  LED
);

    localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

    logic [6:0]  r_disp [7];
    logic [1:0]  r_btn_s1;
    logic [1:0]  r_btn_s2;
    logic [1:0]  r_stable;
    logic [1:0]  r_pressed;
    logic [15:0] r_cnt [2];
    logic [9:0]  r_sw_s1;
    logic [9:0]  r_sw_s2;

    logic        w_hit;
    logic [3:0]  w_idx;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_rise;
    logic [1:0]  w_clr;
    logic [31:0] w_rd_val;
    logic        w_unused;

    // Word offsets 0..9 within the CR region (0x2000-0x2024).
    assign w_idx = CrAddr[5:2];
    assign w_hit = (CrAddr[13:12] == 2'b10) && (CrAddr[11:6] == 6'b0) && (w_idx <= 4'd9);
    assign w_wr  = CrWrEn & w_hit & CrByteEn[0];
    assign w_rd  = CrRdEn & w_hit;

    assign w_unused = ^{CrAddr[31:14], CrAddr[1:0], CrByteEn[3:1], CrWrData[31:7]};

    always_ff @(posedge Clock) begin
        if (!RstN) begin
            for (int i = 0; i < 7; i++) begin
                r_disp[i] <= 7'd0;
            end
        end else if (w_wr && !w_idx[3] && (w_idx[2:0] != 3'd7)) begin
            r_disp[w_idx[2:0]] <= CrWrData[6:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (!RstN) begin
            r_btn_s1 <= 2'b0;
            r_btn_s2 <= 2'b0;
            r_sw_s1  <= 10'd0;
            r_sw_s2  <= 10'd0;
        end else begin
            r_btn_s1 <= {Button_1, Button_0};
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= Switch;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_comb begin
        w_rise = 2'b0;
        for (int k = 0; k < 2; k++) begin
            w_rise[k] = r_btn_s2[k] & ~r_stable[k] & (r_cnt[k] == CntMax);
        end
        w_clr[0] = w_rd && (w_idx == 4'd7);
        w_clr[1] = w_rd && (w_idx == 4'd8);
    end

    always_ff @(posedge Clock) begin
        if (!RstN) begin
            r_stable  <= 2'b0;
            r_pressed <= 2'b0;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_btn_s2[k] == r_stable[k]) begin
                    r_cnt[k] <= 16'd0;
                end else if (r_cnt[k] == CntMax) begin
                    r_stable[k] <= r_btn_s2[k];
                    r_cnt[k]    <= 16'd0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 16'd1;
                end
                // A new press beats a coincident read-to-clear.
                if (w_rise[k]) begin
                    r_pressed[k] <= 1'b1;
                end else if (w_clr[k]) begin
                    r_pressed[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rd_val = 32'h0;
        case (w_idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: w_rd_val = {25'b0, r_disp[w_idx[2:0]]};
            4'd7:    w_rd_val = {30'b0, r_pressed[0], r_stable[0]};
            4'd8:    w_rd_val = {30'b0, r_pressed[1], r_stable[1]};
            4'd9:    w_rd_val = {22'b0, r_sw_s2};
            default: w_rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!RstN) begin
            CrRdData <= 32'h0;
        end else begin
            CrRdData <= w_rd ? w_rd_val : 32'h0;
        end
    end

    assign SEG7_0 = r_disp[0];
    assign SEG7_1 = r_disp[1];
    assign SEG7_2 = r_disp[2];
    assign SEG7_3 = r_disp[3];
    assign SEG7_4 = r_disp[4];
    assign SEG7_5 = r_disp[5];
    assign LED    = r_disp[6];

endmodule

// File: tb/tb_rvc_asap_cr_mem.sv
// Directed bench for rvc_asap_cr_mem: read expectations are queued when a load is driven
// and compared by a monitor the cycle after.
module tb_rvc_asap_cr_mem;

    localparam int unsigned Deb = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic        rden;
    logic        wren;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        btn0;
    logic        btn1;
    logic [9:0]  sw;
    logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, led;
    logic [6:0]  outs [7];
    logic [6:0]  model [7];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb [$];
    logic        mon_rd;
    logic [31:0] mon_addr;
    logic [31:0] mon_exp;

    rvc_asap_cr_mem #(.DEBOUNCE_CYCLES(Deb)) dut (
        .Clock    (clk),
        .RstN     (rstn),
        .CrAddr   (addr),
        .CrRdEn   (rden),
        .CrWrEn   (wren),
        .CrByteEn (be),
        .CrWrData (wdata),
        .CrRdData (rdata),
        .Button_0 (btn0),
        .Button_1 (btn1),
        .Switch   (sw),
        .SEG7_0   (seg0),
        .SEG7_1   (seg1),
        .SEG7_2   (seg2),
        .SEG7_3   (seg3),
        .SEG7_4   (seg4),
        .SEG7_5   (seg5),
        .LED      (led)
    );

    assign outs[0] = seg0;
    assign outs[1] = seg1;
    assign outs[2] = seg2;
    assign outs[3] = seg3;
    assign outs[4] = seg4;
    assign outs[5] = seg5;
    assign outs[6] = led;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        addr = a;
        rden = 1'b1;
        sb.push_back(e);
        cyc();
        rden = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr  = a;
        wdata = d;
        be    = b;
        wren  = 1'b1;
        cyc();
        wren  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), {25'b0, outs[i]}, {25'b0, model[i]});
        end
    endtask

    // Loads sampled at an edge are checked just after that edge.
    always @(posedge clk) begin
        mon_rd   = rden && rstn;
        mon_addr = addr;
        #1;
        if (mon_rd) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL sb_empty: observed read of %h with no expectation queued", mon_addr);
            end else begin
                mon_exp = sb.pop_front();
                chk($sformatf("rd_%h", mon_addr), rdata, mon_exp);
            end
        end
    end

    initial begin
        rstn  = 1'b0;
        addr  = 32'h2000;
        rden  = 1'b1;
        wren  = 1'b1;
        be    = 4'h1;
        wdata = 32'h7F;
        btn0  = 1'b0;
        btn1  = 1'b0;
        sw    = 10'd0;
        for (int i = 0; i < 7; i++) model[i] = 7'd0;

        // Reset overrides a write and a read to 0x2000.
        repeat (3) begin
            cyc();
            chk("rst_seg0", {25'b0, seg0}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
        end
        rden = 1'b0;
        wren = 1'b0;
        rstn = 1'b1;
        cyc();
        check_regs("after_rst");

        // Write and read back SEG7_1; upper data bits must be dropped.
        wr(32'h2004, 32'hA5A5_A5FF, 4'h1);
        model[1] = 7'h7F;
        chk("seg1_write", {25'b0, seg1}, 32'h7F);
        rd(32'h2004, 32'h7F);
        wr(32'h2004, 32'h0000_0000, 4'h0);
        chk("seg1_be0", {25'b0, seg1}, 32'h7F);

        for (int i = 0; i < 7; i++) begin
            wr(32'h2000 + 32'(4 * i), 32'((i + 1) * 17), 4'h1);
            model[i] = 7'((i + 1) * 17);
        end
        check_regs("fill");

        // Out-of-region, undefined and read-only offsets take no writes.
        wr(32'h1004, 32'h55, 4'h1);
        wr(32'h2028, 32'h55, 4'h1);
        wr(32'h201C, 32'h55, 4'h1);
        wr(32'h3000, 32'h55, 4'h1);
        check_regs("decode");
        rd(32'h2028, 32'h0);
        rd(32'h1004, 32'h0);
        rd(32'h3018, 32'h0);

        // Same-cycle read and write of LED returns the old value.
        addr  = 32'h2018;
        wdata = 32'h3A;
        be    = 4'h1;
        rden  = 1'b1;
        wren  = 1'b1;
        sb.push_back({25'b0, model[6]});
        cyc();
        rden = 1'b0;
        wren = 1'b0;
        model[6] = 7'h3A;
        chk("led_rw", {25'b0, led}, 32'h3A);
        rd(32'h2018, 32'h3A);

        // Back-to-back reads with no idle cycle.
        rden = 1'b1;
        for (int i = 0; i < 7; i++) begin
            addr = 32'h2000 + 32'(4 * i);
            sb.push_back({25'b0, model[i]});
            cyc();
        end
        rden = 1'b0;

        // Switch: two-flop path, not yet visible on the first edge.
        sw = 10'h2A5;
        rd(32'h2024, 32'h0);
        cyc();
        rd(32'h2024, 32'h2A5);

        // Glitch shorter than the debounce window is ignored.
        btn0 = 1'b1;
        repeat (5) cyc();
        btn0 = 1'b0;
        repeat (12) cyc();
        rd(32'h201C, 32'h0);

        // Held press: stable rises on edge 10 from the first sample, coinciding with a read.
        btn0 = 1'b1;
        repeat (8) cyc();
        rd(32'h201C, 32'h0);
        rd(32'h201C, 32'h0);
        rd(32'h201C, 32'h3);
        rd(32'h201C, 32'h1);
        btn0 = 1'b0;
        repeat (14) cyc();
        rd(32'h201C, 32'h0);

        btn1 = 1'b1;
        repeat (12) cyc();
        rd(32'h201C, 32'h0);
        rd(32'h2020, 32'h3);
        rd(32'h2020, 32'h1);
        btn1 = 1'b0;
        repeat (14) cyc();
        rd(32'h2020, 32'h0);

        // Reset mid-debounce restarts the count.
        btn0 = 1'b1;
        repeat (6) cyc();
        rstn = 1'b0;
        cyc();
        for (int i = 0; i < 7; i++) model[i] = 7'd0;
        check_regs("mid_rst");
        rstn = 1'b1;
        repeat (8) cyc();
        rd(32'h201C, 32'h0);
        rd(32'h201C, 32'h0);
        rd(32'h201C, 32'h3);
        btn0 = 1'b0;

        repeat (2) cyc();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
